// File: rtl/sram_ctrl_16b_if.sv
// Request/response bus between the cache controller and sram_ctrl_16b.
// The master issues one 32-bit word read or write. The slave answers with a
// one-cycle ready pulse and, for reads, the assembled word.
interface sram_ctrl_16b_if;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        readEn;
  logic        writeEn;
  logic [31:0] readData;
  logic        ready;

  modport master (
    output address, writeData, readEn, writeEn,
    input  readData, ready
  );

  modport slave (
    input  address, writeData, readEn, writeEn,
    output readData, ready
  );
endinterface

// File: rtl/sram_ctrl_16b.sv
// sram_ctrl_16b: splits each 32-bit word request into two 16-bit accesses on an
// asynchronous SRAM. The low half goes to word address {w,0} and the high half
// to {w,1}. Each half lasts HALF_CYCLES clocks. On a write, WE_N is released on
// the last cycle of each half so that address and data hold past the write.
// Optional feature macro: SRAM_PERF_CNT_EN adds read and write completion
// counters (rdCount/wrCount).
module sram_ctrl_16b #(
  parameter int unsigned HALF_CYCLES = 3,     // clocks per 16-bit half, >= 2
  parameter int unsigned BASE_ADDR   = 1024   // byte address of SRAM word 0
) (
  input  logic             clk,
  input  logic             rst,
  sram_ctrl_16b_if.slave   bus,
  inout  wire  [15:0]      SRAM_DQ,
  output logic [17:0]      SRAM_ADDR,
  output logic             SRAM_WE_N,
  output logic             SRAM_CE_N,
  output logic             SRAM_OE_N,
  output logic             SRAM_UB_N,
  output logic             SRAM_LB_N
`ifdef SRAM_PERF_CNT_EN
  ,
  output logic [31:0]      rdCount,
  output logic [31:0]      wrCount
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  localparam int               CNT_W     = $clog2(HALF_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(HALF_CYCLES - 1);
  // The base is split into word and byte parts so that the borrow out of the
  // ignored byte bits still reaches the word address.
  localparam logic [16:0]      BASE_WORD = 17'((BASE_ADDR >> 2) & 32'h0001_FFFF);
  localparam logic [1:0]       BASE_BYTE = 2'(BASE_ADDR & 32'd3);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_is_write;
  logic [16:0]      r_word;
  logic             r_half;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;

  logic             w_req;
  logic             w_last;
  logic             w_accept;
  logic             w_ready;
  logic             w_we_n;
  logic             w_dq_oe;
  logic             w_sample_lo;
  logic             w_sample_hi;
  logic             w_borrow;
  logic [16:0]      w_eff_word;
  logic [15:0]      w_dq_out;

  assign w_req      = bus.readEn | bus.writeEn;
  assign w_last     = (r_cnt == CNT_LAST);
  assign w_borrow   = (bus.address[1:0] < BASE_BYTE);
  assign w_eff_word = bus.address[18:2] - BASE_WORD - 17'(w_borrow);
  assign w_dq_out   = r_half ? r_wdata[31:16] : r_wdata[15:0];

  // Next state, half-access counter and SRAM strobes for the current state.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_ready     = 1'b0;
    w_we_n      = 1'b1;
    w_dq_oe     = 1'b0;
    w_sample_lo = 1'b0;
    w_sample_hi = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_accept    = 1'b1;
          w_state_nxt = S_LO;
          w_cnt_nxt   = '0;
        end
      end
      S_LO, S_HI: begin
        w_dq_oe = r_is_write;
        // The last cycle of a write half releases WE_N while data and address hold.
        w_we_n  = ~(r_is_write & ~w_last);
        if (w_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (r_state == S_LO) ? S_HI : S_DONE;
          w_sample_lo = ~r_is_write & (r_state == S_LO);
          w_sample_hi = ~r_is_write & (r_state == S_HI);
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        w_ready     = 1'b1;
        w_state_nxt = S_IDLE;
        // The edge that leaves DONE also accepts a new request, so
        // back-to-back words are separated by only the ready cycle.
        if (w_req) begin
          w_accept    = 1'b1;
          w_state_nxt = S_LO;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register, request capture, half select and read-data assembly.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // here sees the values from before the edge.
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_is_write <= 1'b0;
      r_word     <= '0;
      r_half     <= 1'b0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_is_write <= bus.writeEn;          // write wins when both are asserted
        r_word     <= w_eff_word;
        r_half     <= 1'b0;
        r_wdata    <= bus.writeData;
      end else if (r_state == S_LO && w_last) begin
        r_half <= 1'b1;
      end
      if (w_sample_lo) r_rdata[15:0]  <= SRAM_DQ;
      if (w_sample_hi) r_rdata[31:16] <= SRAM_DQ;
    end
  end

`ifdef SRAM_PERF_CNT_EN
  // Completed-word counters; each one advances on the DONE cycle of its operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdCount <= '0;
      wrCount <= '0;
    end else if (r_state == S_DONE) begin
      if (r_is_write) wrCount <= wrCount + 32'd1;
      else            rdCount <= rdCount + 32'd1;
    end
  end
`endif

  assign bus.ready    = w_ready;
  assign bus.readData = r_rdata;
  assign SRAM_ADDR    = {r_word, r_half};
  assign SRAM_WE_N    = w_we_n;
  assign SRAM_DQ      = w_dq_oe ? w_dq_out : 16'bz;
  assign SRAM_CE_N    = 1'b0;
  assign SRAM_OE_N    = 1'b0;
  assign SRAM_UB_N    = 1'b0;
  assign SRAM_LB_N    = 1'b0;

endmodule
